// File: rtl/regdump_pkg.sv
// regdump_pkg: default sizes and dump FSM state encoding shared by the
// register dump controller and its write arbiter.
package regdump_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_CSUM} state_t;
endpackage

// File: rtl/regdump_wr_arbiter.sv
// regdump_wr_arbiter: fixed-priority mux onto the register file write port;
// pipeline write-back always wins, debug writes wait for an idle write-back slot.
module regdump_wr_arbiter
    import regdump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_w_addr,
    input  logic [DATA_W-1:0] wb_w_data,
    input  logic              dbg_wr_en,
    input  logic [ADDR_W-1:0] dbg_w_addr,
    input  logic [DATA_W-1:0] dbg_w_data,
    output logic              dbg_wr_ack,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data
);
    always_comb begin
        dbg_wr_ack = dbg_wr_en & ~wb_wr_en;
        rf_wr_en   = wb_wr_en | dbg_wr_ack;
        rf_w_addr  = wb_wr_en ? wb_w_addr : dbg_w_addr;
        rf_w_data  = wb_wr_en ? wb_w_data : dbg_w_data;
    end
endmodule

// File: rtl/registers_dump_ctrl.sv
// registers_dump_ctrl: streams every register out over a valid/ready port while
// arbitrating register file writes; REGDUMP_CHECKSUM_EN appends an XOR checksum word.
module registers_dump_ctrl
    import regdump_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_w_addr,
    input  logic [DATA_W-1:0] wb_w_data,
    input  logic              dbg_wr_en,
    input  logic [ADDR_W-1:0] dbg_w_addr,
    input  logic [DATA_W-1:0] dbg_w_data,
    output logic              dbg_wr_ack,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic [ADDR_W-1:0] rf_r_addr,
    input  logic [DATA_W-1:0] rf_r_data,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              dump_done_q, dump_done_d;
    logic              at_last;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    regdump_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_arb (
        .wb_wr_en   (wb_wr_en),
        .wb_w_addr  (wb_w_addr),
        .wb_w_data  (wb_w_data),
        .dbg_wr_en  (dbg_wr_en),
        .dbg_w_addr (dbg_w_addr),
        .dbg_w_data (dbg_w_data),
        .dbg_wr_ack (dbg_wr_ack),
        .rf_wr_en   (rf_wr_en),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data)
    );

    assign at_last   = idx_q == LAST_IDX;
    assign rf_r_addr = (state_q == S_READ) ? idx_q[ADDR_W-1:0] : '0;
    assign out_data  = out_data_q;
    assign dump_busy = state_q != S_IDLE;
    assign dump_done = dump_done_q;
`ifdef REGDUMP_CHECKSUM_EN
    assign out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
    assign out_last  = state_q == S_CSUM;
`else
    assign out_valid = state_q == S_SEND;
    assign out_last  = (state_q == S_SEND) && at_last;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        dump_done_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: if (dump_req) begin
                state_d = S_READ;
                idx_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            S_READ: begin
                out_data_d = rf_r_data;
                state_d    = S_SEND;
            end
            S_SEND: if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                csum_d = csum_q ^ out_data_q;
`endif
                if (!at_last) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end else begin
`ifdef REGDUMP_CHECKSUM_EN
                    // the checksum word already folds in the final register
                    out_data_d = csum_q ^ out_data_q;
                    state_d    = S_CSUM;
`else
                    state_d     = S_IDLE;
                    dump_done_d = 1'b1;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: if (out_ready) begin
                state_d     = S_IDLE;
                dump_done_d = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            dump_done_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            dump_done_q <= dump_done_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_registers_dump_ctrl.sv
// tb_registers_dump_ctrl: directed stimulus with a stream-level reference model
// checked every cycle; define REGDUMP_CHECKSUM_EN to exercise the checksum word.
module tb_registers_dump_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int NW = NR + 1;
`else
    localparam int NW = NR;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wb_wr_en, dbg_wr_en, dbg_wr_ack, rf_wr_en;
    logic [AW-1:0] wb_w_addr, dbg_w_addr, rf_w_addr, rf_r_addr;
    logic [DW-1:0] wb_w_data, dbg_w_data, rf_w_data, rf_r_data;
    logic          dump_req, dump_busy, dump_done, out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;

    logic [DW-1:0] regs [NR];

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_wr_en) regs[rf_w_addr] <= rf_w_data;
    assign rf_r_data = regs[rf_r_addr];

    registers_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_wr_en(wb_wr_en), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
        .dbg_wr_en(dbg_wr_en), .dbg_w_addr(dbg_w_addr), .dbg_w_data(dbg_w_data),
        .dbg_wr_ack(dbg_wr_ack),
        .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
        .dump_req(dump_req), .dump_busy(dump_busy), .dump_done(dump_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    int            checks, failures;
    logic [DW-1:0] shadow [NR];
    logic [DW-1:0] exp_w [NW];
    logic [DW-1:0] rx [$];
    int            ptr, done_cnt;
    bit            active, done_exp;

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream is the register snapshot at dump start, plus its XOR when enabled.
    task automatic start_stream();
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NR; i++) begin
            exp_w[i] = shadow[i];
            x ^= shadow[i];
        end
`ifdef REGDUMP_CHECKSUM_EN
        exp_w[NR] = x;
`endif
        active = 1'b1;
        ptr = 0;
    endtask

    task automatic mon_step();
        bit was_active;
        if (!rst_n) begin
            active = 1'b0;
            ptr = 0;
            done_exp = 1'b0;
            chk1("rst_valid", out_valid, 1'b0);
            chk1("rst_busy", dump_busy, 1'b0);
            chk1("rst_done", dump_done, 1'b0);
            return;
        end
        chk1("arb_rf_wr_en", rf_wr_en, wb_wr_en | dbg_wr_en);
        chk1("arb_ack", dbg_wr_ack, dbg_wr_en & ~wb_wr_en);
        if (wb_wr_en | dbg_wr_en) begin
            chkw("arb_addr", 32'(rf_w_addr), 32'(wb_wr_en ? wb_w_addr : dbg_w_addr));
            chkw("arb_data", rf_w_data, wb_wr_en ? wb_w_data : dbg_w_data);
        end
        chk1("dump_done", dump_done, done_exp);
        if (dump_done) done_cnt++;
        chk1("dump_busy", dump_busy, active);
        done_exp = 1'b0;
        was_active = active;
        if (out_valid) begin
            chk1("valid_only_when_active", active, 1'b1);
            if (active) begin
                chkw("out_data", out_data, exp_w[ptr]);
                chk1("out_last", out_last, ptr == NW - 1);
                if (out_ready) begin
                    rx.push_back(out_data);
                    ptr++;
                    if (ptr == NW) begin
                        active = 1'b0;
                        done_exp = 1'b1;
                    end
                end
            end
        end else begin
            chk1("out_last_idle", out_last, 1'b0);
        end
        if (dump_req && !was_active) start_stream();
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_wr_en = 1'b1;
        wb_w_addr = a;
        wb_w_data = d;
        shadow[a] = d;
        tick();
        wb_wr_en = 1'b0;
    endtask

    // mode 0: always ready, 1: ready toggles, 2: dump_req re-asserted mid-stream
    task automatic run_dump(input int mode, output int base, output int nwords, output int ndone);
        int dbase, cyc;
        base = rx.size();
        dbase = done_cnt;
        out_ready = 1'b1;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        cyc = 0;
        while (done_cnt == dbase && cyc < 1000) begin
            out_ready = (mode == 1) ? cyc[0] : 1'b1;
            dump_req = (mode == 2) && (cyc >= 20) && (cyc < 30);
            tick();
            cyc++;
        end
        dump_req = 1'b0;
        out_ready = 1'b1;
        chk1("dump_completes", done_cnt != dbase, 1'b1);
        repeat (4) tick();
        chk1("idle_after_dump", dump_busy, 1'b0);
        nwords = rx.size() - base;
        ndone = done_cnt - dbase;
    endtask

    initial begin
        int base, nw, nd, cyc, dbase;
        checks = 0;
        failures = 0;
        ptr = 0;
        done_cnt = 0;
        active = 1'b0;
        done_exp = 1'b0;
        wb_wr_en = 1'b0; wb_w_addr = '0; wb_w_data = '0;
        dbg_wr_en = 1'b0; dbg_w_addr = '0; dbg_w_data = '0;
        dump_req = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none
        repeat (3) tick();
        chkw("reset_out_data", out_data, '0);
        chk1("reset_out_last", out_last, 1'b0);
        chkw("reset_rf_r_addr", 32'(rf_r_addr), '0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) wb_write(AW'(i), '0);
        wb_write(5'd0, 32'd25);
        wb_write(5'd1, 32'd50);
        wb_write(5'd2, 32'd100);

        wb_wr_en = 1'b1; wb_w_addr = 5'd3; wb_w_data = 32'd200;
        dbg_wr_en = 1'b1; dbg_w_addr = 5'd4; dbg_w_data = 32'd7;
        #1;
        chkw("collide_addr", 32'(rf_w_addr), 32'd3);
        chk1("collide_ack", dbg_wr_ack, 1'b0);
        tick();
        wb_wr_en = 1'b0;
        shadow[3] = 32'd200;
        #1;
        chkw("dbg_addr", 32'(rf_w_addr), 32'd4);
        chkw("dbg_data", rf_w_data, 32'd7);
        chk1("dbg_ack", dbg_wr_ack, 1'b1);
        tick();
        dbg_wr_en = 1'b0;
        shadow[4] = 32'd7;
        chkw("r3_written", regs[3], 32'd200);
        chkw("r4_written", regs[4], 32'd7);
        wb_write(5'd4, '0);
        tick();

        run_dump(0, base, nw, nd);
        chkw("d0_words", nw, NW);
        chkw("d0_done", nd, 1);
        chkw("d0_w0", rx[base], 32'd25);
        chkw("d0_w1", rx[base+1], 32'd50);
        chkw("d0_w2", rx[base+2], 32'd100);
        chkw("d0_w3", rx[base+3], 32'd200);
`ifdef REGDUMP_CHECKSUM_EN
        chkw("d0_checksum", rx[base+NR], 32'h87);
`endif

        run_dump(1, base, nw, nd);
        chkw("d1_words", nw, NW);
        chkw("d1_done", nd, 1);
        chkw("d1_w0", rx[base], 32'd25);
        chkw("d1_w3", rx[base+3], 32'd200);

        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        cyc = 0;
        while (!(out_valid && ptr == 10) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk1("reach_word10", out_valid, 1'b1);
        dbase = done_cnt;
        rst_n = 1'b0;
        #1;
        chk1("abort_valid", out_valid, 1'b0);
        chk1("abort_busy", dump_busy, 1'b0);
        chkw("abort_data", out_data, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chkw("abort_no_done", done_cnt - dbase, 0);

        run_dump(0, base, nw, nd);
        chkw("d2_words", nw, NW);
        chkw("d2_w0", rx[base], 32'd25);

        run_dump(2, base, nw, nd);
        chkw("d3_words", nw, NW);
        chkw("d3_done", nd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
